// File: rtl/legv8_instr_encoder_if.sv
// Request/write bus of the LEGv8 instruction encoder.
// The master side (loader) issues encode requests and observes the
// instruction-memory write port; the slave side (encoder) accepts requests
// and drives the write port.
interface legv8_instr_encoder_if #(
    parameter int ADDR_W = 8
);
    // Request handshake
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rn;
    logic [4:0]        in_rm;
    logic [25:0]       in_imm;

    // Instruction memory write port
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid, in_op, in_rd, in_rn, in_rm, in_imm,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rn, in_rm, in_imm,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/legv8_instr_encoder.sv
// LEGv8 instruction encoder.
// Turns abstract requests (op, registers, immediate) into 32-bit R/D/CB-format
// words and writes them to consecutive word addresses of instruction memory,
// starting at byte address 0 after every start pulse. Requests with an
// out-of-range immediate or an illegal op are consumed and flagged on err.
// Optional feature: define LEGV8_ENC_BRANCH_EN to encode op 7 as the
// unconditional branch B; otherwise op 7 is illegal.
// Requires 4*DEPTH <= 2**ADDR_W.
module legv8_instr_encoder #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    legv8_instr_encoder_if.slave bus,
    output logic                 err,
    output logic                 full,
    output logic [ADDR_W-2:0]    count
);
    localparam int CNT_W = ADDR_W - 1;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_ORR  = 3'd3,
        OP_LDUR = 3'd4,
        OP_STUR = 3'd5,
        OP_CBZ  = 3'd6,
        OP_B    = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FULL
    } state_t;

    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
`ifdef LEGV8_ENC_BRANCH_EN
    localparam logic [5:0]  OPC_B    = 6'b000101;
`endif

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [CNT_W-1:0]  cnt;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              err_q;
    logic              full_q;

    op_t               op;
    logic [31:0]       enc_word;
    logic              enc_ok;
    logic              accept;
    logic              last_slot;

    assign op = op_t'(bus.in_op);

    // A start pulse takes priority over any request in the same cycle, so
    // ready drops combinationally while start is high.
    assign bus.in_ready  = (state == S_RUN) && !start;
    assign accept        = bus.in_valid && bus.in_ready;
    assign last_slot     = (cnt == CNT_W'(DEPTH - 1));

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign err           = err_q;
    assign full          = full_q;
    assign count         = cnt;

    // Encode the current request and decide whether its immediate/op is legal.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case leaves it unassigned (which would infer a latch).
        enc_word = '0;
        enc_ok   = 1'b0;
        case (op)
            OP_ADD: begin
                enc_word = {OPC_ADD, bus.in_rm, 6'b0, bus.in_rn, bus.in_rd};
                enc_ok   = 1'b1;
            end
            OP_SUB: begin
                enc_word = {OPC_SUB, bus.in_rm, 6'b0, bus.in_rn, bus.in_rd};
                enc_ok   = 1'b1;
            end
            OP_AND: begin
                enc_word = {OPC_AND, bus.in_rm, 6'b0, bus.in_rn, bus.in_rd};
                enc_ok   = 1'b1;
            end
            OP_ORR: begin
                enc_word = {OPC_ORR, bus.in_rm, 6'b0, bus.in_rn, bus.in_rd};
                enc_ok   = 1'b1;
            end
            OP_LDUR: begin
                enc_word = {OPC_LDUR, bus.in_imm[8:0], 2'b00, bus.in_rn, bus.in_rd};
                enc_ok   = (bus.in_imm[25:9] == 17'd0);
            end
            OP_STUR: begin
                enc_word = {OPC_STUR, bus.in_imm[8:0], 2'b00, bus.in_rn, bus.in_rd};
                enc_ok   = (bus.in_imm[25:9] == 17'd0);
            end
            OP_CBZ: begin
                // The 19-bit branch offset is signed: upper bits must replicate bit 18.
                enc_word = {OPC_CBZ, bus.in_imm[18:0], bus.in_rd};
                enc_ok   = (bus.in_imm[25:19] == {7{bus.in_imm[18]}});
            end
            OP_B: begin
`ifdef LEGV8_ENC_BRANCH_EN
                enc_word = {OPC_B, bus.in_imm};
                enc_ok   = 1'b1;
`else
                enc_word = '0;
                enc_ok   = 1'b0;
`endif
            end
            default: begin
                enc_word = '0;
                enc_ok   = 1'b0;
            end
        endcase
    end

    // Control FSM with write pointer, word count and registered write/err/full outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            ptr         <= '0;
            cnt         <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // right-hand side sees the values from before this clock edge.
            mem_we_q <= 1'b0;
            err_q    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        ptr   <= '0;
                        cnt   <= '0;
                    end
                end
                S_RUN: begin
                    if (start) begin
                        ptr <= '0;
                        cnt <= '0;
                    end else if (accept) begin
                        if (enc_ok) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= ptr;
                            mem_wdata_q <= enc_word;
                            ptr         <= ptr + ADDR_W'(4);
                            cnt         <= cnt + CNT_W'(1);
                            if (last_slot) begin
                                state  <= S_FULL;
                                full_q <= 1'b1;
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_FULL: begin
                    if (start) begin
                        state  <= S_RUN;
                        ptr    <= '0;
                        cnt    <= '0;
                        full_q <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Self-checking bench for legv8_instr_encoder (DEPTH=4).
// A driver issues directed and random requests, predicts each outcome with a
// behavioural model and queues it; a monitor compares every write/err pulse
// against the queue head, including the cycle in which it appears.
module tb_legv8_instr_encoder;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    localparam longint P5  = 64'd32;
    localparam longint P12 = 64'd4096;
    localparam longint P16 = 64'd65536;
    localparam longint P21 = 64'd2097152;
    localparam longint P24 = 64'd16777216;
    localparam longint P26 = 64'd67108864;

    logic              clk;
    logic              rst;
    logic              start;
    logic              err;
    logic              full;
    logic [ADDR_W-2:0] count;

    legv8_instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    legv8_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bus   (bus),
        .err   (err),
        .full  (full),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit     is_err;
        longint addr;
        longint data;
        int     due;
    } exp_t;

    exp_t   q[$];
    int     errors = 0;
    int     checks = 0;
    int     neg_cnt = 0;

    // Model state: 0 idle, 1 run, 2 full
    int     m_state = 0;
    longint m_ptr = 0;
    longint m_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference encoder from the instruction format tables.
    function automatic bit model_encode(input int op, input longint rd, input longint rn,
                                        input longint rm, input longint imm, output longint word);
        bit ok;
        ok   = 1'b0;
        word = 0;
        case (op)
            0: begin word = 'h458 * P21 + rm * P16 + rn * P5 + rd; ok = 1'b1; end
            1: begin word = 'h658 * P21 + rm * P16 + rn * P5 + rd; ok = 1'b1; end
            2: begin word = 'h450 * P21 + rm * P16 + rn * P5 + rd; ok = 1'b1; end
            3: begin word = 'h550 * P21 + rm * P16 + rn * P5 + rd; ok = 1'b1; end
            4: begin word = 'h7C2 * P21 + (imm % 512) * P12 + rn * P5 + rd; ok = (imm < 512); end
            5: begin word = 'h7C0 * P21 + (imm % 512) * P12 + rn * P5 + rd; ok = (imm < 512); end
            6: begin
                word = 'hB4 * P24 + (imm % (P12 * 128)) * P5 + rd;
                ok   = (imm < P12 * 64) || (imm >= P26 - P12 * 64);
            end
            default: begin
`ifdef LEGV8_ENC_BRANCH_EN
                word = 5 * P26 + imm;
                ok   = 1'b1;
`else
                word = 0;
                ok   = 1'b0;
`endif
            end
        endcase
        return ok;
    endfunction

    // Issue one request for a cycle; the model decides whether it is taken.
    task automatic send(input int op, input int rd, input int rn, input int rm, input longint imm);
        bit     taken;
        bit     ok;
        longint word;
        exp_t   e;
        @(negedge clk);
        start      = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_op  = 3'(op);
        bus.in_rd  = 5'(rd);
        bus.in_rn  = 5'(rn);
        bus.in_rm  = 5'(rm);
        bus.in_imm = 26'(imm);
        #1;
        taken = (m_state == 1) && !rst;
        check("in_ready", {63'd0, bus.in_ready}, {63'd0, taken});
        @(posedge clk);
        if (taken) begin
            ok     = model_encode(op, rd, rn, rm, imm, word);
            e.due  = neg_cnt + 1;
            e.addr = m_ptr;
            e.data = word % (P16 * P16);
            e.is_err = !ok;
            q.push_back(e);
            if (ok) begin
                m_ptr = m_ptr + 4;
                m_cnt = m_cnt + 1;
                if (m_cnt == DEPTH) m_state = 2;
            end
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        start        = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
    endtask

    task automatic pulse_start(input bit with_req);
        @(negedge clk);
        start        = 1'b1;
        bus.in_valid = with_req;
        bus.in_op    = 3'($urandom_range(0, 7));
        #1;
        check("ready_during_start", {63'd0, bus.in_ready}, 64'd0);
        @(posedge clk);
        m_state = 1;
        m_ptr   = 0;
        m_cnt   = 0;
        @(negedge clk);
        start        = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    // Assert reset just after an edge; any write in flight must vanish.
    task automatic do_reset();
        #1;
        rst = 1'b1;
        q.delete();
        m_state = 0;
        m_ptr   = 0;
        m_cnt   = 0;
        #1;
        check("rst_mem_we", {63'd0, bus.mem_we}, 64'd0);
        check("rst_ready", {63'd0, bus.in_ready}, 64'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic longint rand_imm();
        longint edges[6];
        edges[0] = 511;
        edges[1] = 512;
        edges[2] = P12 * 64 - 1;
        edges[3] = P12 * 64;
        edges[4] = P26 - P12 * 64;
        edges[5] = P26 - P12 * 64 - 1;
        case ($urandom_range(0, 4))
            0: return longint'($urandom_range(0, 511));
            1: return longint'($urandom_range(0, 262143));
            2: return P26 - longint'($urandom_range(1, 262144));
            3: return longint'($urandom) % P26;
            default: return edges[$urandom_range(0, 5)];
        endcase
    endfunction

    // Monitor: compare each write/err pulse and the count/full levels.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            neg_cnt++;
            check("count", {57'd0, count}, m_cnt);
            check("full", {63'd0, full}, {63'd0, (m_state == 2)});
            check("we_and_err", {63'd0, bus.mem_we & err}, 64'd0);
            if (bus.mem_we || err) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: we=%0b err=%0b addr=0x%0h data=0x%0h expected none",
                             bus.mem_we, err, bus.mem_addr, bus.mem_wdata);
                end else begin
                    e = q.pop_front();
                    check("is_err", {63'd0, err}, {63'd0, e.is_err});
                    check("latency", neg_cnt, e.due);
                    if (!e.is_err) begin
                        check("mem_addr", {56'd0, bus.mem_addr}, e.addr);
                        check("mem_wdata", {32'd0, bus.mem_wdata}, e.data);
                    end
                end
            end else if (q.size() > 0 && q[0].due <= neg_cnt) begin
                e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_output: got none expected %s addr=0x%0h data=0x%0h",
                         e.is_err ? "err" : "write", e.addr, e.data);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op    = '0;
        bus.in_rd    = '0;
        bus.in_rn    = '0;
        bus.in_rm    = '0;
        bus.in_imm   = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_mem_we", {63'd0, bus.mem_we}, 64'd0);
        check("reset_err", {63'd0, err}, 64'd0);
        check("reset_full", {63'd0, full}, 64'd0);
        check("reset_count", {57'd0, count}, 64'd0);
        check("reset_ready", {63'd0, bus.in_ready}, 64'd0);
        check("reset_addr", {56'd0, bus.mem_addr}, 64'd0);
        check("reset_wdata", {32'd0, bus.mem_wdata}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Idle: request is not taken before start
        send(0, 1, 2, 3, 0);
        pulse_start(1'b0);
        // ADD, then back-to-back LDUR and CBZ
        send(0, 1, 2, 3, 0);
        send(4, 5, 6, 0, 8);
        send(6, 7, 0, 0, 3);
        // Out-of-range LDUR, then a legal write at the unchanged address
        send(4, 1, 1, 0, 'h200);
        send(1, 9, 10, 11, 0);
        // Full: extra requests ignored
        send(2, 3, 4, 5, 0);
        send(3, 3, 4, 5, 0);
        idle_cycle();
        // Restart from full, then op 7
        pulse_start(1'b1);
        send(7, 0, 0, 0, 2);
        send(5, 2, 3, 0, 511);
        // Reset the cycle after an accept
        send(0, 4, 5, 6, 0);
        do_reset();
        send(0, 4, 5, 6, 0);
        idle_cycle();
        pulse_start(1'b0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 10) begin
                pulse_start($urandom_range(0, 1) == 1);
            end else if (r < 20) begin
                idle_cycle();
            end else if (r < 22) begin
                send($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), rand_imm());
                do_reset();
            end else begin
                send($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), rand_imm());
            end
        end

        repeat (3) idle_cycle();
        check("queue_drained", q.size(), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
